control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle Moore FSM that drives exec_unit. Consumes IR and C/N/Z; issues every
//  datapath and memory enable (fetch, decode, execute). Sits beside exec_unit in the
//  CPU top; memory sees Address/D_out from exec_unit and mw_en from this block.
// PARAMETERS
//  (none) - ISA field positions and encodings are fixed constants in cpu_pkg
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   asynchronous, active-low reset
//  IR        in   16  instruction register from exec_unit
//  C, N, Z   in   1   live ALU flags from exec_unit
//  adr_sel   out  1   0=PC drives Address, 1=Reg_out drives Address
//  s_sel     out  1   1=DS into ALU S operand (loads)
//  pc_sel    out  1   0=PC+sext(IR[7:0]), 1=ALU result into PC
//  pc_ld     out  1   load PC
//  pc_inc    out  1   PC <= PC+1
//  ir_ld     out  1   IR <= DS
//  W_en      out  1   register-file write enable
//  W_Adr     out  3   write address
//  R_Adr     out  3   R operand address
//  S_Adr     out  3   S operand address
//  ALU_OP    out  4   ALU function
//  mw_en     out  1   memory write strobe
//  halted    out  1   1 in HALT or ILLEGAL
//  illegal   out  1   1 in ILLEGAL only
//  retire_cnt out 16  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  ISA: IR[15:13] class. 000 ALU: ALU_OP=IR[12:9], W=IR[8:6], R=IR[5:3], S=IR[2:0].
//   001 LD W<=M[R]. 010 ST M[R]<=S. 100 BR cond=IR[12:10], PC<=PC+sext(IR[7:0]).
//   101 JR PC<=R. 111 HALT. 011/110 illegal. BR cond: 000 always, 001 Z, 010 !Z,
//   011 C, 100 !C, 101 N, 110 !N, 111 illegal.
//  States: RST, FETCH, DECODE, EX_ALU, EX_LD, EX_ST, EX_BR, EX_JR, HALT, ILLEGAL.
//  reset low: state=RST, flag reg {c,n,z}=0, retire_cnt=0; all enables 0, addr/op 0.
//  RST -> FETCH (one idle cycle after deassert).
//  FETCH: adr_sel=0, ir_ld=1, pc_inc=1 -> DECODE. Branch base is PC+1.
//  DECODE: no enables; select EX_* by class; 111 -> HALT; illegal -> ILLEGAL.
//  EX_ALU: W_en=1, ALU_OP=IR[12:9], addresses from IR; flag reg <= {C,N,Z}.
//  EX_LD: adr_sel=1, s_sel=1, ALU_OP=ALU_PASS_S, W_en=1. Flags unchanged.
//  EX_ST: adr_sel=1, ALU_OP=ALU_PASS_S, mw_en=1. Flags unchanged.
//  EX_BR: pc_sel=0, pc_ld=(cond true on registered flags). Not-taken = no PC change.
//  EX_JR: ALU_OP=ALU_PASS_R, pc_sel=1, pc_ld=1.
//  All EX_* -> FETCH. Latency: every instruction 3 cycles (FETCH, DECODE, EX).
//  HALT/ILLEGAL: absorbing; exit only via reset. All enables 0.
//  Never assert pc_ld and pc_inc together; never W_en and mw_en together.
//  Reset mid-EX: pending W_en/pc_ld/mw_en drop immediately (combinational decode of state).
//  Flags are registered only by EX_ALU; branches test the last ALU result.
// CONFIGURATION
//  CU_RETIRE_CNT_EN defined: 16-bit counter increments on each EX_* -> FETCH
//   transition; wraps 16'hFFFF -> 0; HALT/ILLEGAL do not count.
//  Undefined: retire_cnt tied to 16'h0000; no counter flops.
// STRUCTURE
//  cpu_pkg: state enum, class codes, BR cond codes, ALU_PASS_S=4'h0, ALU_PASS_R=4'h1,
//   IR field bit-range constants.
//  Sub-module cu_branch_eval: combinational {cond, c,n,z} -> take, cond_illegal.
// TESTING
//  Reset low mid-EX_ST -> mw_en=0 same cycle; after release RST->FETCH, retire_cnt=0.
//  IR=16'h0? ALU ADD W=1,R=2,S=3 -> FETCH/DECODE/EX_ALU, W_en=1 only in 3rd cycle, W_Adr=1.
//  ALU result Z=1 then BR cond=001 off=8'hFC -> pc_ld=1, pc_sel=0; cond=010 -> pc_ld=0.
//  LD W=4,R=5 -> adr_sel=1, s_sel=1, ALU_OP=4'h0, W_en=1; ST -> mw_en=1, W_en=0.
//  IR[15:13]=3'b011 or BR cond=111 -> ILLEGAL, illegal=1, halted=1, no enables ever.
//  HALT after 5 instrs -> halted=1; retire_cnt=5 with CU_RETIRE_CNT_EN, 0 without.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ISA constants and the control FSM state encoding.
//   state_e          control_unit state encoding
//   CLS_*            instruction class codes found in IR[15:13]
//   BR_*             branch condition codes found in IR[12:10]
//   ALU_PASS_*       ALU functions the control unit issues on its own
//   IR_*_HI / _LO    instruction field bit positions
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_RST     = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EX_ALU  = 4'd3,
        ST_EX_LD   = 4'd4,
        ST_EX_ST   = 4'd5,
        ST_EX_BR   = 4'd6,
        ST_EX_JR   = 4'd7,
        ST_HALT    = 4'd8,
        ST_ILLEGAL = 4'd9
    } state_e;

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_LD   = 3'b001;
    localparam logic [2:0] CLS_ST   = 3'b010;
    localparam logic [2:0] CLS_BR   = 3'b100;
    localparam logic [2:0] CLS_JR   = 3'b101;
    localparam logic [2:0] CLS_HALT = 3'b111;

    localparam logic [2:0] BR_ALWAYS = 3'b000;
    localparam logic [2:0] BR_Z      = 3'b001;
    localparam logic [2:0] BR_NZ     = 3'b010;
    localparam logic [2:0] BR_C      = 3'b011;
    localparam logic [2:0] BR_NC     = 3'b100;
    localparam logic [2:0] BR_N      = 3'b101;
    localparam logic [2:0] BR_NN     = 3'b110;

    localparam logic [3:0] ALU_PASS_S = 4'h0;
    localparam logic [3:0] ALU_PASS_R = 4'h1;

    localparam int IR_CLS_HI  = 15;
    localparam int IR_CLS_LO  = 13;
    localparam int IR_OP_HI   = 12;
    localparam int IR_OP_LO   = 9;
    localparam int IR_COND_HI = 12;
    localparam int IR_COND_LO = 10;
    localparam int IR_W_HI    = 8;
    localparam int IR_W_LO    = 6;
    localparam int IR_R_HI    = 5;
    localparam int IR_R_LO    = 3;
    localparam int IR_S_HI    = 2;
    localparam int IR_S_LO    = 0;

endpackage

// File: rtl/cu_branch_eval.sv
// cu_branch_eval: combinational branch condition evaluation.
//   cond         in  3  branch condition code
//   c, n, z      in  1  registered ALU flags
//   take         out 1  condition is true
//   cond_illegal out 1  condition code is reserved
module cu_branch_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       c,
    input  logic       n,
    input  logic       z,
    output logic       take,
    output logic       cond_illegal
);

    always_comb begin
        take         = 1'b0;
        cond_illegal = 1'b0;
        unique case (cond)
            BR_ALWAYS: take = 1'b1;
            BR_Z:      take = z;
            BR_NZ:     take = ~z;
            BR_C:      take = c;
            BR_NC:     take = ~c;
            BR_N:      take = n;
            BR_NN:     take = ~n;
            default:   cond_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore FSM sequencing fetch/decode/execute for exec_unit.
// Optional feature macro: CU_RETIRE_CNT_EN (retired-instruction counter).
//   clk, reset (async, active-low), IR[15:0], C/N/Z live ALU flags
//   adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, W_en, W_Adr, R_Adr, S_Adr,
//   ALU_OP, mw_en, halted, illegal, retire_cnt[15:0]
//
// state      | meaning
// RST        | idle cycle after reset release
// FETCH      | IR <= M[PC], PC <= PC+1
// DECODE     | select execute state from instruction class
// EX_ALU     | register write from ALU, capture flags
// EX_LD      | W <= M[R]
// EX_ST      | M[R] <= S
// EX_BR      | conditional PC-relative branch on captured flags
// EX_JR      | PC <= R
// HALT       | stopped by HALT instruction, exit only by reset
// ILLEGAL    | stopped by reserved encoding, exit only by reset
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        adr_sel,
    output logic        s_sel,
    output logic        pc_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        W_en,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic [3:0]  ALU_OP,
    output logic        mw_en,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retire_cnt
);

    state_e     state_q, state_d;
    logic [2:0] flags_q, flags_d;   // {c, n, z} from the last EX_ALU
    logic       br_take, br_cond_illegal;
    logic [2:0] cls;

    assign cls = IR[IR_CLS_HI:IR_CLS_LO];

    cu_branch_eval u_branch_eval (
        .cond         (IR[IR_COND_HI:IR_COND_LO]),
        .c            (flags_q[2]),
        .n            (flags_q[1]),
        .z            (flags_q[0]),
        .take         (br_take),
        .cond_illegal (br_cond_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RST;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        unique case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (cls)
                    CLS_ALU:  state_d = ST_EX_ALU;
                    CLS_LD:   state_d = ST_EX_LD;
                    CLS_ST:   state_d = ST_EX_ST;
                    CLS_BR:   state_d = br_cond_illegal ? ST_ILLEGAL : ST_EX_BR;
                    CLS_JR:   state_d = ST_EX_JR;
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_ILLEGAL;
                endcase
            end
            ST_EX_ALU: begin
                state_d = ST_FETCH;
                flags_d = {C, N, Z};
            end
            ST_EX_LD, ST_EX_ST, ST_EX_BR, ST_EX_JR: state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_RST;
        endcase
    end

    // Outputs decode state_q only, so an async reset drops them immediately.
    always_comb begin
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        pc_sel  = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        W_en    = 1'b0;
        W_Adr   = 3'd0;
        R_Adr   = 3'd0;
        S_Adr   = 3'd0;
        ALU_OP  = 4'h0;
        mw_en   = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_EX_ALU: begin
                W_en   = 1'b1;
                ALU_OP = IR[IR_OP_HI:IR_OP_LO];
                W_Adr  = IR[IR_W_HI:IR_W_LO];
                R_Adr  = IR[IR_R_HI:IR_R_LO];
                S_Adr  = IR[IR_S_HI:IR_S_LO];
            end
            ST_EX_LD: begin
                adr_sel = 1'b1;
                s_sel   = 1'b1;
                ALU_OP  = ALU_PASS_S;
                W_en    = 1'b1;
                W_Adr   = IR[IR_W_HI:IR_W_LO];
                R_Adr   = IR[IR_R_HI:IR_R_LO];
            end
            ST_EX_ST: begin
                adr_sel = 1'b1;
                ALU_OP  = ALU_PASS_S;
                mw_en   = 1'b1;
                R_Adr   = IR[IR_R_HI:IR_R_LO];
                S_Adr   = IR[IR_S_HI:IR_S_LO];
            end
            ST_EX_BR: begin
                pc_sel = 1'b0;
                pc_ld  = br_take;
            end
            ST_EX_JR: begin
                ALU_OP = ALU_PASS_R;
                pc_sel = 1'b1;
                pc_ld  = 1'b1;
                R_Adr  = IR[IR_R_HI:IR_R_LO];
            end
            ST_HALT: halted = 1'b1;
            ST_ILLEGAL: begin
                halted  = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CU_RETIRE_CNT_EN
    logic [15:0] retire_q, retire_d;
    logic        ex_state;

    // Every EX_* state leaves for FETCH, so being in one means an instruction retires.
    assign ex_state = (state_q == ST_EX_ALU) || (state_q == ST_EX_LD) ||
                      (state_q == ST_EX_ST)  || (state_q == ST_EX_BR) ||
                      (state_q == ST_EX_JR);
    assign retire_d = ex_state ? retire_q + 16'd1 : retire_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retire_q <= 16'h0000;
        else        retire_q <= retire_d;
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    typedef logic [22:0] vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] IR;
    logic        C, N, Z;
    logic        adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, W_en, mw_en, halted, illegal;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic [3:0]  ALU_OP;
    logic [15:0] retire_cnt;

    int checks  = 0;
    int errors  = 0;
    int retired = 0;
    vec_t exp_q[$];
    vec_t obs;

    always #5 clk = ~clk;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .C          (C),
        .N          (N),
        .Z          (Z),
        .adr_sel    (adr_sel),
        .s_sel      (s_sel),
        .pc_sel     (pc_sel),
        .pc_ld      (pc_ld),
        .pc_inc     (pc_inc),
        .ir_ld      (ir_ld),
        .W_en       (W_en),
        .W_Adr      (W_Adr),
        .R_Adr      (R_Adr),
        .S_Adr      (S_Adr),
        .ALU_OP     (ALU_OP),
        .mw_en      (mw_en),
        .halted     (halted),
        .illegal    (illegal),
        .retire_cnt (retire_cnt)
    );

    assign obs = {adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, W_en,
                  W_Adr, R_Adr, S_Adr, ALU_OP, mw_en, halted, illegal};

    function automatic vec_t ev(input bit adr, input bit ss, input bit pcs, input bit pcl,
                                input bit pci, input bit irl, input bit wen,
                                input bit [2:0] wa, input bit [2:0] ra, input bit [2:0] sa,
                                input bit [3:0] op, input bit mw, input bit h, input bit il);
        return {adr, ss, pcs, pcl, pci, irl, wen, wa, ra, sa, op, mw, h, il};
    endfunction

    vec_t V_FETCH, V_IDLE, V_HALT, V_ILL;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, e);
        end
    endtask

    task automatic chk_retire(input string tag);
        logic [15:0] e;
`ifdef CU_RETIRE_CNT_EN
        e = 16'(retired);
`else
        e = 16'h0000;
`endif
        checks++;
        assert (retire_cnt === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, retire_cnt, e);
        end
    endtask

    // Entered with the DUT sampled in FETCH; leaves it sampled in the next FETCH.
    task automatic run_instr(input string tag, input logic [15:0] ir, input vec_t ex);
        IR = ir;
        exp_q.push_back(V_FETCH);
        exp_q.push_back(V_IDLE);
        exp_q.push_back(ex);
        check_next({tag, "_fetch"});
        step();
        check_next({tag, "_decode"});
        step();
        check_next({tag, "_ex"});
        step();
        retired++;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        retired = 0;
        step();
    endtask

    initial begin
        V_FETCH = ev(0,0,0,0,1,1,0,3'd0,3'd0,3'd0,4'h0,0,0,0);
        V_IDLE  = '0;
        V_HALT  = ev(0,0,0,0,0,0,0,3'd0,3'd0,3'd0,4'h0,0,1,0);
        V_ILL   = ev(0,0,0,0,0,0,0,3'd0,3'd0,3'd0,4'h0,0,1,1);

        reset = 1'b0;
        IR = 16'h0000;
        {C, N, Z} = 3'b000;
        step();
        step();
        chk("reset_outputs", V_IDLE);
        chk_retire("reset_retire");
        #2 reset = 1'b1;
        step();

        // ST R=5 S=6, interrupted by reset while in EX_ST
        IR = 16'h402E;
        exp_q.push_back(V_FETCH);
        exp_q.push_back(V_IDLE);
        exp_q.push_back(ev(1,0,0,0,0,0,0,3'd0,3'd5,3'd6,4'h0,1,0,0));
        check_next("st_fetch");
        step();
        check_next("st_decode");
        step();
        check_next("st_ex");
        reset = 1'b0;
        #1;
        chk("st_reset_mid_ex", V_IDLE);
        chk_retire("st_reset_retire");
        #1 reset = 1'b1;
        step();
        chk("after_reset_fetch", V_FETCH);
        chk_retire("after_reset_retire");

        // ADD W=1 R=2 S=3
        run_instr("alu_add", 16'h0453, ev(0,0,0,0,0,0,1,3'd1,3'd2,3'd3,4'h2,0,0,0));
        // ALU op 3, result Z=1 captured into the flag register
        {C, N, Z} = 3'b001;
        run_instr("alu_z", 16'h07FF, ev(0,0,0,0,0,0,1,3'd7,3'd7,3'd7,4'h3,0,0,0));
        // live flags now disagree; branches must use the captured ones
        {C, N, Z} = 3'b100;
        run_instr("br_z_taken", 16'h84FC, ev(0,0,0,1,0,0,0,3'd0,3'd0,3'd0,4'h0,0,0,0));
        run_instr("br_nz_not", 16'h88FC, V_IDLE);
        run_instr("ld", 16'h2128, ev(1,1,0,0,0,0,1,3'd4,3'd5,3'd0,4'h0,0,0,0));
        chk_retire("retire_after_5");

        // HALT
        IR = 16'hE000;
        exp_q.push_back(V_FETCH);
        exp_q.push_back(V_IDLE);
        check_next("halt_fetch");
        step();
        check_next("halt_decode");
        for (int i = 0; i < 3; i++) begin
            step();
            exp_q.push_back(V_HALT);
            check_next("halt_hold");
        end
        chk_retire("retire_in_halt");

        // JR R=3, then reserved class 011
        reset_pulse();
        run_instr("jr", 16'hA018, ev(0,0,1,1,0,0,0,3'd0,3'd3,3'd0,4'h1,0,0,0));
        chk_retire("retire_after_jr");
        IR = 16'h6000;
        exp_q.push_back(V_FETCH);
        exp_q.push_back(V_IDLE);
        check_next("ill_cls_fetch");
        step();
        check_next("ill_cls_decode");
        for (int i = 0; i < 3; i++) begin
            step();
            exp_q.push_back(V_ILL);
            check_next("ill_cls_hold");
        end
        chk_retire("retire_in_illegal");

        // branch with reserved condition 111
        reset_pulse();
        IR = 16'h9C00;
        exp_q.push_back(V_FETCH);
        exp_q.push_back(V_IDLE);
        check_next("ill_br_fetch");
        step();
        check_next("ill_br_decode");
        for (int i = 0; i < 2; i++) begin
            step();
            exp_q.push_back(V_ILL);
            check_next("ill_br_hold");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
